instr_cache_responder: RTL and testbench
========================================

Name: instr_cache_responder

Overview:
- Responder side of the dual-port instruction-cache read interface used by the fetch loader.
- Serves two word reads per cycle from a direct-mapped, flop-based cache with combinational lookup.
- On a miss, a refill FSM fetches one full line from the memory side.
- Sits between the fetch loader (initiator) and the instruction-memory/L2 port.

Parameters:
XLEN, 32, address width
SETS, 16, number of lines (power of 2)
LINE_WORDS, 4, 32-bit words per line (power of 2)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
read[2]  in  1  lookup request per port
address_in[2]  in  XLEN  byte address per port
hit[2]  out  1  port's word is valid this cycle
instr[2]  out  32  instruction word for the port
address_out[2]  out  XLEN  echo of address_in for the port
flush  in  1  invalidate the whole cache
mem_read  out  1  line refill request
mem_address  out  XLEN  line-aligned refill address
mem_data  in  LINE_WORDS*32  refill line; word 0 is in the LSBs
mem_ready  in  1  mem_data valid; single-cycle pulse
miss_count  out  32  saturating count of refills started

Behaviour:
- Address split:
  - Bits [1:0] are ignored.
  - Word = next log2(LINE_WORDS) bits.
  - Index = next log2(SETS) bits.
  - Tag = remaining upper bits.
- Lookup is combinational. hit[i] = read[i] & valid[index] & (tag match) & (state == IDLE) & !flush.
- instr[i] is the selected word when hit[i] = 1, otherwise 0.
- address_out[i] = address_in[i] always.
- FSM has two states, IDLE and REQ.
- IDLE:
  - If some port has read = 1 and misses, latch the miss line address, increment miss_count (saturating at all-ones), and go to REQ on the next edge.
  - Port 0 has priority over port 1.
  - If both ports miss in the same line, exactly one refill is issued.
  - If they miss in different lines, port 1's refill is issued only after port 0's line is installed and port 1 is re-looked-up in IDLE.
- REQ:
  - mem_read = 1 and mem_address = latched line address (word bits and [1:0] zero), both registered and stable until mem_ready.
  - On the edge where mem_ready = 1: write mem_data into the line, set its tag and valid, deassert mem_read, return to IDLE.
  - A hit is available in the first IDLE cycle after that edge.
  - mem_ready while in IDLE is ignored.
- All hit outputs are 0 while in REQ; there is no hit-under-miss.
- Eviction: the refill overwrites the indexed line regardless of its prior contents.
- flush:
  - Clears all valid bits on the edge where it is sampled, in any state.
  - In REQ, the outstanding request still completes, but the returned line is discarded (valid stays 0). A drop flag is set by the flush and cleared on return to IDLE.
  - A flush and a refill write in the same edge resolve to the flush winning.
- Reset (reset = 0, asynchronous):
  - All valid bits 0, state IDLE, mem_read 0, mem_address 0, miss_count 0, drop flag 0.
  - hit = 0 and instr = 0 while reset is low.
  - Data/tag arrays need not be cleared.
  - A reset during REQ abandons the request; a later mem_ready is ignored.
- Simultaneous read on both ports hitting the same word returns the same data on both ports.

Test Plan:
1. Cold miss, same line: after reset, read both ports, 0x100 and 0x104 -> mem_read = 1 next cycle with mem_address = 0x100, miss_count = 1. Pulse mem_ready with words {0xA,0xB,0xC,0xD} -> next cycle hit = 1/1, instr = 0xA/0xB.
2. Dual miss, different lines: port 0 at 0x200, port 1 at 0x310 -> refill 0x200 first, then 0x310; both hit after the second fill; miss_count = 2.
3. Conflict eviction: fill 0x100, then read 0x1100 (same index, different tag) -> miss and refill 0x1100; a subsequent read of 0x100 misses again.
4. Flush during REQ: miss on 0x400, assert flush for one cycle, then mem_ready -> line not installed; re-read of 0x400 issues a new request; miss_count = 2.
5. Reset mid-refill: pull reset low in REQ -> mem_read = 0 immediately; a stale mem_ready after release is ignored; all lookups miss.
6. Idle/no-read: read = 0 on both ports with a valid line -> hit = 0, instr = 0, mem_read stays 0, miss_count unchanged.

Source files
------------

// File: rtl/instr_cache_responder.sv
// instr_cache_responder
// Responder side of the dual-port instruction-cache read interface.
// Direct-mapped, flop-based cache with combinational lookup on two ports,
// plus a two-state refill FSM that fetches one full line on a miss.
//
// Ports:
//   clock, reset           system clock, asynchronous active-low reset
//   read[1:0]              lookup request per port
//   address_in[2]          byte address per port
//   hit[1:0]               port's word is valid this cycle
//   instr[2]               selected instruction word (0 when no hit)
//   address_out[2]         echo of address_in
//   flush                  invalidate the whole cache
//   mem_read, mem_address  registered line refill request, line-aligned
//   mem_data, mem_ready    refill line (word 0 in LSBs), single-cycle valid
//   miss_count             saturating count of refills started
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | lookups served; a miss latches the line address and starts a refill
// REQ   | refill outstanding, mem_read held high until mem_ready
module instr_cache_responder #(
    parameter int XLEN       = 32,
    parameter int SETS       = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [1:0]                 read,
    input  logic [XLEN-1:0]            address_in [2],
    output logic [1:0]                 hit,
    output logic [31:0]                instr [2],
    output logic [XLEN-1:0]            address_out [2],
    input  logic                       flush,
    output logic                       mem_read,
    output logic [XLEN-1:0]            mem_address,
    input  logic [LINE_WORDS*32-1:0]   mem_data,
    input  logic                       mem_ready,
    output logic [31:0]                miss_count
);

    localparam int WB    = $clog2(LINE_WORDS);
    localparam int IB    = $clog2(SETS);
    localparam int OFF   = WB + 2;
    localparam int TAG_W = XLEN - OFF - IB;

    typedef enum logic {IDLE, REQ} state_t;

    state_t                      state;
    logic                        drop;
    logic [SETS-1:0]             valid;
    logic [TAG_W-1:0]            tag_mem  [SETS];
    logic [LINE_WORDS*32-1:0]    data_mem [SETS];

    logic [1:0]                  miss;
    logic [XLEN-1:0]             line_addr [2];
    logic [IB-1:0]               fill_idx;
    logic [TAG_W-1:0]            fill_tag;

    assign fill_idx = mem_address[OFF+IB-1:OFF];
    assign fill_tag = mem_address[XLEN-1:OFF+IB];

    for (genvar p = 0; p < 2; p++) begin : g_port
        logic [IB-1:0]             idx;
        logic [WB-1:0]             word;
        logic [TAG_W-1:0]          tag;
        logic [LINE_WORDS*32-1:0]  line;

        assign idx  = address_in[p][OFF+IB-1:OFF];
        assign word = address_in[p][OFF-1:2];
        assign tag  = address_in[p][XLEN-1:OFF+IB];
        assign line = data_mem[idx];

        assign hit[p] = read[p] & valid[idx] & (tag_mem[idx] == tag)
                        & (state == IDLE) & ~flush;
        assign instr[p]       = hit[p] ? line[word*32 +: 32] : 32'h0;
        assign address_out[p] = address_in[p];
        assign miss[p]        = read[p] & ~hit[p];
        assign line_addr[p]   = {address_in[p][XLEN-1:OFF], {OFF{1'b0}}};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            valid       <= '0;
            mem_read    <= 1'b0;
            mem_address <= '0;
            miss_count  <= '0;
            drop        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Port 0 wins; a different-line miss on port 1 is picked up
                    // by the re-lookup after port 0's line is installed.
                    if (miss != 2'b00) begin
                        mem_address <= miss[0] ? line_addr[0] : line_addr[1];
                        mem_read    <= 1'b1;
                        if (miss_count != '1) miss_count <= miss_count + 32'd1;
                        state       <= REQ;
                    end
                end
                REQ: begin
                    if (flush) drop <= 1'b1;
                    if (mem_ready) begin
                        if (!drop) valid[fill_idx] <= 1'b1;
                        mem_read <= 1'b0;
                        drop     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            // Placed last so a flush overrides a same-edge refill install.
            if (flush) valid <= '0;
        end
    end

    // Tag/data arrays carry no reset; valid bits alone qualify them.
    always_ff @(posedge clock) begin
        if (state == REQ && mem_ready) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= mem_data;
        end
    end

endmodule

// File: tb/tb_instr_cache_responder.sv
module tb_instr_cache_responder;

    logic         clock = 1'b0;
    logic         reset;
    logic [1:0]   read;
    logic [31:0]  address_in [2];
    logic [1:0]   hit;
    logic [31:0]  instr [2];
    logic [31:0]  address_out [2];
    logic         flush;
    logic         mem_read;
    logic [31:0]  mem_address;
    logic [127:0] mem_data;
    logic         mem_ready;
    logic [31:0]  miss_count;

    int n_cmp = 0;
    int n_err = 0;

    string       name_q [$];
    logic [31:0] exp_q  [$];

    instr_cache_responder dut (
        .clock       (clock),
        .reset       (reset),
        .read        (read),
        .address_in  (address_in),
        .hit         (hit),
        .instr       (instr),
        .address_out (address_out),
        .flush       (flush),
        .mem_read    (mem_read),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .mem_ready   (mem_ready),
        .miss_count  (miss_count)
    );

    always #5 clock = ~clock;

    task automatic expect_val(input string name, input logic [31:0] val);
        name_q.push_back(name);
        exp_q.push_back(val);
    endtask

    task automatic chk(input logic [31:0] obs);
        string       n;
        logic [31:0] e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard_empty observed=%h", obs);
            return;
        end
        n = name_q.pop_front();
        e = exp_q.pop_front();
        assert (obs === e) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", n, obs, e);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset         = 1'b0;
        read          = 2'b00;
        address_in[0] = 32'h0;
        address_in[1] = 32'h0;
        flush         = 1'b0;
        mem_data      = '0;
        mem_ready     = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
    endtask

    task automatic fill(input logic [127:0] data);
        mem_data  = data;
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        mem_data  = '0;
        #1;
    endtask

    task automatic set_rd(input logic [1:0] r, input logic [31:0] a0, input logic [31:0] a1);
        read          = r;
        address_in[0] = a0;
        address_in[1] = a1;
        #1;
    endtask

    localparam logic [127:0] LINE_A = {32'hD, 32'hC, 32'hB, 32'hA};
    localparam logic [127:0] LINE_B = {32'h2003, 32'h2002, 32'h2001, 32'h2000};
    localparam logic [127:0] LINE_C = {32'h3103, 32'h3102, 32'h3101, 32'h3100};
    localparam logic [127:0] LINE_D = {32'h1103, 32'h1102, 32'h1101, 32'h1100};

    initial begin
        // ---- Test 1: cold miss, same line ----
        do_reset();
        expect_val("rst_miss_count", 32'd0); chk(miss_count);
        expect_val("rst_mem_read", 32'd0);   chk(32'(mem_read));
        expect_val("rst_mem_addr", 32'd0);   chk(mem_address);
        set_rd(2'b11, 32'h100, 32'h104);
        expect_val("t1_cold_hit", 32'd0);    chk(32'(hit));
        expect_val("t1_addr_echo", 32'h104); chk(address_out[1]);
        tick();
        expect_val("t1_mem_read", 32'd1);    chk(32'(mem_read));
        expect_val("t1_mem_addr", 32'h100);  chk(mem_address);
        expect_val("t1_miss_cnt", 32'd1);    chk(miss_count);
        expect_val("t1_req_hit", 32'd0);     chk(32'(hit));
        fill(LINE_A);
        expect_val("t1_hit", 32'd3);         chk(32'(hit));
        expect_val("t1_instr0", 32'hA);      chk(instr[0]);
        expect_val("t1_instr1", 32'hB);      chk(instr[1]);
        expect_val("t1_mem_read_low", 32'd0); chk(32'(mem_read));
        tick();
        expect_val("t1_no_extra_miss", 32'd1); chk(miss_count);

        // ---- Test 2: dual miss, different lines ----
        do_reset();
        set_rd(2'b11, 32'h200, 32'h310);
        tick();
        expect_val("t2_addr_first", 32'h200); chk(mem_address);
        fill(LINE_B);
        expect_val("t2_hit_partial", 32'd1);  chk(32'(hit));
        expect_val("t2_instr0", 32'h2000);    chk(instr[0]);
        tick();
        expect_val("t2_addr_second", 32'h310); chk(mem_address);
        expect_val("t2_mem_read", 32'd1);      chk(32'(mem_read));
        expect_val("t2_req_hit", 32'd0);       chk(32'(hit));
        fill(LINE_C);
        expect_val("t2_hit_both", 32'd3);     chk(32'(hit));
        expect_val("t2_instr0b", 32'h2000);   chk(instr[0]);
        expect_val("t2_instr1", 32'h3100);    chk(instr[1]);
        expect_val("t2_miss_cnt", 32'd2);     chk(miss_count);

        // ---- Test 3: conflict eviction ----
        do_reset();
        set_rd(2'b01, 32'h100, 32'h0);
        tick();
        fill(LINE_A);
        expect_val("t3_hit_first", 32'd1);    chk(32'(hit));
        set_rd(2'b01, 32'h1100, 32'h0);
        expect_val("t3_conflict_miss", 32'd0); chk(32'(hit));
        tick();
        expect_val("t3_addr_evict", 32'h1100); chk(mem_address);
        fill(LINE_D);
        expect_val("t3_hit_new", 32'd1);      chk(32'(hit));
        expect_val("t3_instr_new", 32'h1100); chk(instr[0]);
        set_rd(2'b01, 32'h100, 32'h0);
        expect_val("t3_old_miss", 32'd0);     chk(32'(hit));
        expect_val("t3_old_instr", 32'd0);    chk(instr[0]);
        tick();
        expect_val("t3_addr_again", 32'h100); chk(mem_address);
        expect_val("t3_miss_cnt", 32'd3);     chk(miss_count);

        // ---- Test 4: flush during REQ ----
        do_reset();
        set_rd(2'b01, 32'h400, 32'h0);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        expect_val("t4_mem_read_held", 32'd1); chk(32'(mem_read));
        fill(LINE_A);
        expect_val("t4_dropped", 32'd0);      chk(32'(hit));
        tick();
        expect_val("t4_rerequest", 32'd1);    chk(32'(mem_read));
        expect_val("t4_addr", 32'h400);       chk(mem_address);
        expect_val("t4_miss_cnt", 32'd2);     chk(miss_count);
        fill(LINE_A);
        expect_val("t4_hit_after", 32'd1);    chk(32'(hit));

        // ---- Test 5: reset mid-refill ----
        do_reset();
        set_rd(2'b01, 32'h100, 32'h0);
        tick();
        expect_val("t5_in_req", 32'd1);       chk(32'(mem_read));
        #2;
        reset = 1'b0;
        #1;
        expect_val("t5_async_clear", 32'd0);  chk(32'(mem_read));
        expect_val("t5_rst_hit", 32'd0);      chk(32'(hit));
        expect_val("t5_rst_cnt", 32'd0);      chk(miss_count);
        tick();
        reset = 1'b1;
        set_rd(2'b00, 32'h100, 32'h0);
        fill(LINE_A);
        set_rd(2'b01, 32'h100, 32'h0);
        expect_val("t5_stale_ignored", 32'd0); chk(32'(hit));
        expect_val("t5_idle_mem_read", 32'd0); chk(32'(mem_read));

        // ---- Test 6: idle / no read, and same-word dual read ----
        do_reset();
        set_rd(2'b01, 32'h100, 32'h0);
        tick();
        fill(LINE_A);
        set_rd(2'b00, 32'h100, 32'h104);
        expect_val("t6_idle_hit", 32'd0);     chk(32'(hit));
        expect_val("t6_idle_instr", 32'd0);   chk(instr[1]);
        repeat (3) tick();
        expect_val("t6_idle_mem_read", 32'd0); chk(32'(mem_read));
        expect_val("t6_idle_cnt", 32'd1);     chk(miss_count);
        set_rd(2'b11, 32'h108, 32'h108);
        expect_val("t6_same_hit", 32'd3);     chk(32'(hit));
        expect_val("t6_same_i0", 32'hC);      chk(instr[0]);
        expect_val("t6_same_i1", 32'hC);      chk(instr[1]);
        flush = 1'b1;
        #1;
        expect_val("t6_flush_hit", 32'd0);    chk(32'(hit));
        flush = 1'b0;

        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
